booth_r4_seq_mult: RTL and testbench

Sequential, parametrised radix-4 Booth multiplier for signed two's-complement operands. It retires one Booth digit per clock, so an N-digit multiply uses a single shared partial-product adder instead of a combinational adder tree. It sits in the arithmetic datapath where a small, low-area multiplier with a start/done handshake is enough, and it replaces the fixed 4-bit combinational Booth multiplier for wider operands.

---
 rtl/booth_r4_seq_mult_if.sv | 22 ++
 rtl/booth_r4_seq_mult.sv | 114 +++++++++++
 tb/tb_booth_r4_seq_mult.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/booth_r4_seq_mult_if.sv
// Start/operand/result bundle for booth_r4_seq_mult.
// The master drives start/a/b; the slave (the multiplier) returns busy/done/product.
interface booth_r4_seq_mult_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock through a shared adder.
// Optional BOOTH_EARLY_TERM_EN: finish as soon as all remaining multiplier digits are zero.
module booth_r4_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    booth_r4_seq_mult_if.slave   bus
);
    localparam int N  = WIDTH / 2;
    localparam int KW = $clog2(N + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_r;
    logic [WIDTH+1:0]       a_r;
    logic [WIDTH:0]         m_r;
    logic [2*WIDTH-1:0]     acc_r;
    logic [KW-1:0]          k_r;
    logic                   busy_r;
    logic                   done_r;
    logic [2*WIDTH-1:0]     product_r;

    logic [WIDTH+1:0]       pp_s;
    logic [2*WIDTH-1:0]     pp_ext_s;
    logic [2*WIDTH-1:0]     acc_next_s;
    logic [WIDTH:0]         m_next_s;
    logic                   last_s;

    // Radix-4 Booth recoding of one digit into a WIDTH+2-bit partial product.
    function automatic logic [WIDTH+1:0] booth_pp(input logic [2:0] code,
                                                  input logic [WIDTH+1:0] mcand);
        logic [WIDTH+1:0] pp;
        case (code)
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = {mcand[WIDTH:0], 1'b0};
            3'b100:         pp = -{mcand[WIDTH:0], 1'b0};
            3'b101, 3'b110: pp = -mcand;
            default:        pp = {(WIDTH+2){1'b0}};
        endcase
        return pp;
    endfunction

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;

    // Digit datapath: weighted partial product, next accumulator, shifted multiplier, last-digit flag.
    always_comb begin
        last_s     = 1'b0;
        pp_s       = booth_pp(m_r[2:0], a_r);
        pp_ext_s   = {{(WIDTH-2){pp_s[WIDTH+1]}}, pp_s};
        acc_next_s = acc_r + (pp_ext_s << {k_r, 1'b0});
        m_next_s   = {{2{m_r[WIDTH]}}, m_r[WIDTH:2]};
        if (k_r == KW'(N - 1)) begin
            last_s = 1'b1;
        end
`ifdef BOOTH_EARLY_TERM_EN
        // All-zero or all-one remaining bits recode to zero digits only.
        else if ((m_next_s == {(WIDTH+1){1'b0}}) || (m_next_s == {(WIDTH+1){1'b1}})) begin
            last_s = 1'b1;
        end
`endif
        else begin
            last_s = 1'b0;
        end
    end

    // Control FSM with registered busy/done/product.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            a_r       <= {(WIDTH+2){1'b0}};
            m_r       <= {(WIDTH+1){1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            k_r       <= {KW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_r     <= {{2{bus.a[WIDTH-1]}}, bus.a};
                        m_r     <= {bus.b, 1'b0};
                        acc_r   <= {(2*WIDTH){1'b0}};
                        k_r     <= {KW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    acc_r <= acc_next_s;
                    m_r   <= m_next_s;
                    k_r   <= k_r + KW'(1);
                    if (last_s) begin
                        product_r <= acc_next_s;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench for booth_r4_seq_mult at WIDTH=8 and WIDTH=16,
// compared against plain signed multiplication and a digit-count latency model.
module tb_booth_r4_seq_mult;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    booth_r4_seq_mult_if #(.WIDTH(8))  i8 ();
    booth_r4_seq_mult_if #(.WIDTH(16)) i16 ();

    booth_r4_seq_mult #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(i8.slave));
    booth_r4_seq_mult #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(i16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit w16, input logic st, input logic [15:0] av, input logic [15:0] bv);
        if (w16) begin
            i16.start = st; i16.a = av; i16.b = bv;
        end else begin
            i8.start = st; i8.a = av[7:0]; i8.b = bv[7:0];
        end
    endtask

    function automatic logic get_done(input bit w16);
        return w16 ? i16.done : i8.done;
    endfunction

    function automatic logic get_busy(input bit w16);
        return w16 ? i16.busy : i8.busy;
    endfunction

    function automatic longint get_prod(input bit w16);
        return w16 ? longint'($signed(i16.product)) : longint'($signed(i8.product));
    endfunction

    // Expected cycles from start edge to completion edge.
    function automatic int exp_lat(input bit w16, input int bv);
        int n;
        n = w16 ? 8 : 4;
`ifdef BOOTH_EARLY_TERM_EN
        for (int j = 0; j < n; j++) begin
            if (((bv >>> (2*j+1)) == 0) || ((bv >>> (2*j+1)) == -1)) return j + 1;
        end
`endif
        return n;
    endfunction

    // Waits for done after a start edge, checking busy, latency and product.
    task automatic finish_op(input bit w16, input longint ep, input int el, input string tag);
        int lat;
        lat = 0;
        while (get_done(w16) !== 1'b1 && lat < 40) begin
            checks++;
            if (get_busy(w16) !== 1'b1) begin
                errors++;
                $display("FAIL %s busy: got %b expected 1 at cycle %0d", tag, get_busy(w16), lat);
            end
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != el) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", tag, lat, el);
        end
        checks++;
        if (get_busy(w16) !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b expected 0", tag, get_busy(w16));
        end
        checks++;
        if (get_prod(w16) !== ep) begin
            errors++;
            $display("FAIL %s product: got %0d expected %0d", tag, get_prod(w16), ep);
        end
    endtask

    task automatic mul(input bit w16, input int av, input int bv, input string tag);
        @(negedge clk);
        drive(w16, 1'b1, 16'(av), 16'(bv));
        @(posedge clk); #1;
        drive(w16, 1'b0, 16'(av), 16'(bv));
        finish_op(w16, longint'(av) * longint'(bv), exp_lat(w16, bv), tag);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({i8.busy, i8.done, i8.product} !== 18'd0) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b product=%h expected all 0", i8.busy, i8.done, i8.product);
        end
        checks++;
        if ({i16.busy, i16.done, i16.product} !== 34'd0) begin
            errors++;
            $display("FAIL reset16: got busy=%b done=%b product=%h expected all 0", i16.busy, i16.done, i16.product);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        int da[5] = '{7, -128, 127, -1, 0};
        int db[5] = '{-3, -128, -128, 1, 55};
        for (int i = 0; i < 5; i++) mul(1'b0, da[i], db[i], $sformatf("dir%0d", i));
        mul(1'b1, -32768, -32768, "dir16_min");
        mul(1'b1, 32767, -32768, "dir16_mix");
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        drive(1'b0, 1'b1, 16'(9), 16'(-7));
        @(posedge clk); #1;
        lat = 0;
        while (i8.done !== 1'b1 && lat < 40) begin
            drive(1'b0, 1'b1, 16'($urandom), 16'($urandom));
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != exp_lat(1'b0, -7)) begin
            errors++;
            $display("FAIL ignore_latency: got %0d expected %0d", lat, exp_lat(1'b0, -7));
        end
        checks++;
        if (get_prod(1'b0) !== -64'sd63) begin
            errors++;
            $display("FAIL ignore_product: got %0d expected -63", get_prod(1'b0));
        end
        // Still in the done cycle: the next start is accepted at the coming edge.
        drive(1'b0, 1'b1, 16'(5), 16'(6));
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'(5), 16'(6));
        finish_op(1'b0, 64'sd30, exp_lat(1'b0, 6), "back_to_back");
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        drive(1'b0, 1'b1, 16'(100), 16'(100));
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'(0), 16'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({i8.busy, i8.done, i8.product} !== 18'd0) begin
            errors++;
            $display("FAIL abort_state: got busy=%b done=%b product=%h expected all 0", i8.busy, i8.done, i8.product);
        end
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            checks++;
            if (i8.done !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: got done=%b expected 0 at cycle %0d", i8.done, c);
            end
        end
        mul(1'b0, 3, -4, "after_abort");
    endtask

    task automatic test_random(input bit w16, input int count);
        int av;
        int bv;
        int w;
        w = w16 ? 16 : 8;
        for (int i = 0; i < count; i++) begin
            if (w16) begin
                av = int'($signed(16'($urandom)));
                bv = int'($signed(16'($urandom)));
            end else begin
                av = int'($signed(8'($urandom)));
                bv = int'($signed(8'($urandom)));
            end
            if ($urandom_range(0, 15) == 0) av = -(1 << (w - 1));
            if ($urandom_range(0, 15) == 0) bv = -(1 << (w - 1));
            if ($urandom_range(0, 7) == 0)  bv = int'($urandom_range(0, 3)) - 2;
            mul(w16, av, bv, $sformatf("rand%0d_%0d", w, i));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_abort();
        test_random(1'b0, 2000);
        test_random(1'b1, 2000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
